booth_mult_seq: RTL and testbench
=================================

Name: booth_mult_seq

Overview:
- Parametrised sequential radix-2 Booth multiplier: controller FSM and datapath in one block, with a start/done handshake.
- Generalises the 8-bit signed-only Booth controller to any operand width WIDTH.
- Adds unsigned mode, a held product register, busy status, and back-to-back operation.
- Sits beside the ALU as a multi-cycle multiply unit.

Parameters:
- WIDTH, 8, operand width in bits (legal range 2..32).
- CNT_W, $clog2(WIDTH+2), iteration counter width (derived; do not override).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only when the FSM is in IDLE or DONE.
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned; captured with start.
- multiplicand  in  WIDTH  operand M; captured with start.
- multiplier  in  WIDTH  operand Q; captured with start.
- busy  out  1  high in CHECK and SHIFT.
- done  out  1  one-cycle pulse, high only in DONE.
- product  out  2*WIDTH  result; updated on entry to DONE, held until the next DONE.

Behaviour:
- Reset, asynchronous:
  - state = IDLE.
  - busy = 0, done = 0, product = 0.
  - Internal A, Q, q_m1 and counter cleared.
  - Reset mid-operation abandons the operation; no done is issued.
- Internal width: XW = WIDTH+1.
  - M and Q are sign-extended when is_signed = 1, zero-extended otherwise.
  - A is XW bits wide; the {A,Q} pair is 2*XW bits; the counter counts 0..XW.
- Load (IDLE or DONE with start = 1): on that edge:
  - A = 0, Q = ext(multiplier), Mreg = ext(multiplicand), q_m1 = 0, counter = 0.
  - Next state = CHECK.
- CHECK, deciding on the pair {Q[0], q_m1}:
  - 00 or 11: arithmetic right shift of {A,Q,q_m1} by 1; counter++; stay in CHECK, or go to DONE if the counter reaches XW.
  - 01: A = A + Mreg (XW-bit, wrap) -> SHIFT.
  - 10: A = A - Mreg (XW-bit, wrap) -> SHIFT.
- SHIFT:
  - Arithmetic right shift of {A,Q,q_m1}; counter++.
  - Next state = CHECK, or DONE if the counter reaches XW.
- DONE:
  - done = 1 for exactly one cycle.
  - product = low 2*WIDTH bits of {A,Q}, registered on entry.
  - start = 1 reloads and goes to CHECK (back-to-back, no idle cycle); start = 0 goes to IDLE.
- start in CHECK or SHIFT is ignored; operand inputs there are don't-care.
- Latency:
  - Start sampled at edge t0 -> done high in cycle t0 + WIDTH + 2 + K.
  - K = count of i in 0..WIDTH where y_i != y_(i-1), over the extended multiplier y, with y_(-1) = 0.
- Result correctness:
  - Exact for all operand values in both modes, including the most-negative signed value (-2^(WIDTH-1) squared).
  - The XW-bit internal width prevents overflow of the subtraction.
- is_signed and the operands may change freely after the load edge without affecting the result.

Decomposition:
- booth_pkg holds:
  - State enum: IDLE, CHECK, SHIFT, DONE.
  - Booth pair constants: NOP_00, ADD_01, SUB_10, NOP_11.
  - Datapath op codes: HOLD, LOAD, ADD, SUB, ARS.
- One sub-module, booth_mult_datapath, holds:
  - The A, Q, Mreg, q_m1 registers.
  - The XW-bit adder/subtractor and the arithmetic shifter.
  - It is driven by an op code from the FSM in booth_mult_seq.
- The counter and product register stay in the top level.

Test Plan:
- WIDTH = 8, signed, M = -3 (0xFD), Q = 5 (0x05) -> product = 0xFFF1, done one cycle, K = 4, done at t0+14.
- Unsigned, M = 0xFF, Q = 0xFF -> product = 0xFE01. Same operands signed -> product = 0x0001.
- Signed, M = 0x80, Q = 0x80 -> 0x4000. Signed, M = 0x7F, Q = 0x80 -> 0xC080.
- Q = 0x00, any M -> product = 0x0000, K = 0, done exactly at t0+10, busy high for cycles t0+1..t0+9.
- start held high continuously with new operands at each DONE:
  - Each done pulse is followed immediately by a reload.
  - No IDLE cycle between operations.
  - start pulses during busy are ignored.
- Reset asserted mid-operation (cycle t0+5) -> busy, done, product = 0 immediately; the next start gives a correct result.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types for the sequential Booth multiplier: FSM states, Booth pair
// codes and the op codes the controller issues to the datapath.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } booth_state_e;

  // {Q[0], q_m1} recoding pairs
  localparam logic [1:0] NOP_00 = 2'b00;
  localparam logic [1:0] ADD_01 = 2'b01;
  localparam logic [1:0] SUB_10 = 2'b10;
  localparam logic [1:0] NOP_11 = 2'b11;

  typedef enum logic [2:0] {
    HOLD = 3'd0,
    LOAD = 3'd1,
    ADD  = 3'd2,
    SUB  = 3'd3,
    ARS  = 3'd4
  } booth_op_e;

endpackage

// File: rtl/booth_mult_datapath.sv
// Booth datapath: A/Q/M/q_m1 registers, XW-bit add/sub and the arithmetic
// right shift of {A,Q,q_m1}, all driven by a one-hot-free op code.
module booth_mult_datapath
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  booth_op_e          i_op,
  input  logic               i_is_signed,
  input  logic [WIDTH-1:0]   i_multiplicand,
  input  logic [WIDTH-1:0]   i_multiplier,
  output logic [1:0]         o_pair,
  output logic [2*WIDTH-1:0] o_ars_low
);

  localparam int XW = WIDTH + 1;

  logic [XW-1:0] r_a;
  logic [XW-1:0] r_q;
  logic [XW-1:0] r_m;
  logic          r_q_m1;

  logic [XW-1:0]   w_ext_m;
  logic [XW-1:0]   w_ext_q;
  logic [2*XW:0]   w_shift;

  // One extra bit keeps -2^(WIDTH-1) and full unsigned values representable.
  assign w_ext_m = {i_is_signed & i_multiplicand[WIDTH-1], i_multiplicand};
  assign w_ext_q = {i_is_signed & i_multiplier[WIDTH-1], i_multiplier};

  // Shifted {A,Q,q_m1}: A's sign bit is replicated into the new MSB.
  assign w_shift   = {r_a[XW-1], r_a, r_q};
  assign o_ars_low = w_shift[2*WIDTH:1];
  assign o_pair    = {r_q[0], r_q_m1};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_a    <= '0;
      r_q    <= '0;
      r_m    <= '0;
      r_q_m1 <= 1'b0;
    end else begin
      case (i_op)
        LOAD: begin
          r_a    <= '0;
          r_q    <= w_ext_q;
          r_m    <= w_ext_m;
          r_q_m1 <= 1'b0;
        end
        ADD:     r_a <= r_a + r_m;
        SUB:     r_a <= r_a - r_m;
        ARS:     {r_a, r_q, r_q_m1} <= w_shift;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier with start/done handshake, signed and
// unsigned modes, a held product register and back-to-back reload from DONE.
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 2)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output booth_state_e       o_dbg_state
);

  localparam int XW = WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XW - 1);

  booth_state_e       r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [2*WIDTH-1:0] r_product;

  booth_op_e          w_op;
  logic [1:0]         w_pair;
  logic [2*WIDTH-1:0] w_ars_low;
  logic               w_advance;
  logic               w_last;

  booth_mult_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clock          (clock),
    .reset          (reset),
    .i_op           (w_op),
    .i_is_signed    (is_signed),
    .i_multiplicand (multiplicand),
    .i_multiplier   (multiplier),
    .o_pair         (w_pair),
    .o_ars_low      (w_ars_low)
  );

  // A shift happens every SHIFT cycle and on CHECK when the pair needs no add.
  assign w_advance = (r_state == SHIFT) ||
                     ((r_state == CHECK) && ((w_pair == NOP_00) || (w_pair == NOP_11)));
  assign w_last    = (r_cnt == LAST_CNT);

  always_comb begin
    w_op = HOLD;
    case (r_state)
      IDLE, DONE: if (start) w_op = LOAD;
      CHECK: begin
        if (w_pair == ADD_01)      w_op = ADD;
        else if (w_pair == SUB_10) w_op = SUB;
        else                       w_op = ARS;
      end
      SHIFT:   w_op = ARS;
      default: w_op = HOLD;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_cnt   <= '0;
            r_state <= CHECK;
            r_busy  <= 1'b1;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        CHECK, SHIFT: begin
          if (w_advance) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_state   <= DONE;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_product <= w_ars_low;
            end else begin
              r_state <= CHECK;
            end
          end else begin
            r_state <= SHIFT;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign product     = r_product;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed + randomized bench for booth_mult_seq (WIDTH=8) against an
// arithmetic reference model of product and latency.
module tb_booth_mult_seq;
  import booth_pkg::*;

  localparam int W = 8;

  logic           clock;
  logic           reset;
  logic           start;
  logic           is_signed;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;
  booth_state_e   dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [2*W-1:0] exp_q[$];
  int             lat_q[$];

  booth_mult_seq #(.WIDTH(W)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .is_signed    (is_signed),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product),
    .o_dbg_state  (dbg_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [2*W-1:0] ref_product(input logic s, input logic [W-1:0] m,
                                                 input logic [W-1:0] q);
    longint mv, qv;
    mv = s ? longint'($signed(m)) : longint'(m);
    qv = s ? longint'($signed(q)) : longint'(q);
    return (2*W)'(mv * qv);
  endfunction

  function automatic int ref_latency(input logic s, input logic [W-1:0] q);
    logic [W:0] y;
    logic       prev;
    int         k;
    y    = {s & q[W-1], q};
    prev = 1'b0;
    k    = 0;
    for (int i = 0; i <= W; i++) begin
      if (y[i] != prev) k++;
      prev = y[i];
    end
    return W + 2 + k;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Called at posedge+1; starts one op, waits for done, checks everything.
  task automatic run_op(input string tag, input logic s, input logic [W-1:0] m,
                        input logic [W-1:0] q);
    int n, busy_cnt, lat;
    logic [2*W-1:0] expv;
    expv = ref_product(s, m, q);
    lat  = ref_latency(s, q);
    is_signed = s; multiplicand = m; multiplier = q; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    n = 1; busy_cnt = 0;
    while (!done && n < 60) begin
      if (busy) busy_cnt++;
      is_signed    = 1'($urandom_range(0, 1));
      multiplicand = W'($urandom);
      multiplier   = W'($urandom);
      if ($urandom_range(0, 3) == 0) start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      n++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_latency"}, 32'(n), 32'(lat));
    check({tag, "_product"}, 32'(product), 32'(expv));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(lat - 1));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    @(posedge clock); #1;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_held"}, 32'(product), 32'(expv));
  endtask

  initial begin
    int n;
    logic s;
    logic [W-1:0] m, q;

    reset = 1'b1; start = 1'b0; is_signed = 1'b0;
    multiplicand = '0; multiplier = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    reset = 1'b0;
    @(posedge clock); #1;

    run_op("s_m3x5", 1'b1, 8'hFD, 8'h05);
    run_op("u_ffxff", 1'b0, 8'hFF, 8'hFF);
    run_op("s_ffxff", 1'b1, 8'hFF, 8'hFF);
    run_op("s_80x80", 1'b1, 8'h80, 8'h80);
    run_op("s_7fx80", 1'b1, 8'h7F, 8'h80);
    run_op("u_80x80", 1'b0, 8'h80, 8'h80);
    run_op("q_zero", 1'b1, W'($urandom), 8'h00);
    run_op("u_q_zero", 1'b0, W'($urandom), 8'h00);

    for (int i = 0; i < 20; i++) begin
      run_op("rand", 1'($urandom_range(0, 1)), W'($urandom), W'($urandom));
    end

    // Back-to-back: start held high; new operands presented in each DONE cycle.
    s = 1'($urandom_range(0, 1)); m = W'($urandom); q = W'($urandom);
    is_signed = s; multiplicand = m; multiplier = q; start = 1'b1;
    exp_q.push_back(ref_product(s, m, q));
    lat_q.push_back(ref_latency(s, q));
    @(posedge clock); #1;
    for (int op = 0; op < 6; op++) begin
      n = 1;
      while (!done && n < 60) begin
        is_signed    = 1'($urandom_range(0, 1));
        multiplicand = W'($urandom);
        multiplier   = W'($urandom);
        @(posedge clock); #1;
        n++;
      end
      check("b2b_done", 32'(done), 32'd1);
      check("b2b_latency", 32'(n), 32'(lat_q.pop_front()));
      check("b2b_product", 32'(product), 32'(exp_q.pop_front()));
      if (op < 5) begin
        s = 1'($urandom_range(0, 1)); m = W'($urandom); q = W'($urandom);
        is_signed = s; multiplicand = m; multiplier = q;
        exp_q.push_back(ref_product(s, m, q));
        lat_q.push_back(ref_latency(s, q));
      end else begin
        start = 1'b0;
      end
      @(posedge clock); #1;
      check("b2b_done_pulse", 32'(done), 32'd0);
      check("b2b_no_idle", 32'(busy), (op < 5) ? 32'd1 : 32'd0);
    end

    // Reset in cycle t0+5 abandons the operation.
    is_signed = 1'b1; multiplicand = 8'h9B; multiplier = 8'h5A; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    check("mid_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_product", 32'(product), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'(IDLE));
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("post_rst_done", 32'(done), 32'd0);
    run_op("after_rst", 1'b1, 8'hC3, 8'h81);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
